// File: rtl/debug_cmd_bridge_if.sv
// Host byte stream plus debug register bus seen by the command bridge.
// master = bridge side, slave = UART / register block side.
interface debug_cmd_bridge_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  dbg_a;
  logic [15:0] dbg_di;
  logic [15:0] dbg_do;
  logic        dbg_we;
  logic        dbg_rd;
  logic        dbg_ready;
  logic        busy;
  logic        rx_drop;

  modport master (
    input  rx_data, rx_valid, tx_ready, dbg_do, dbg_ready,
    output tx_data, tx_valid, dbg_a, dbg_di, dbg_we, dbg_rd, busy, rx_drop
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, dbg_do, dbg_ready,
    input  tx_data, tx_valid, dbg_a, dbg_di, dbg_we, dbg_rd, busy, rx_drop
  );
endinterface

// File: rtl/debug_cmd_bridge.sv
// Parses 'W' addr dhi dlo / 'R' addr host commands, runs one debug bus
// transfer with ready handshake and timeout, and returns response bytes.
module debug_cmd_bridge #(
  parameter int TO_BITS = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  debug_cmd_bridge_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DHI, S_GET_DLO, S_XFER, S_RESP1, S_RESP2
  } state_t;

  // Last waiting cycle: the counter would reach 2^TO_BITS-1 on this cycle.
  localparam logic [TO_BITS-1:0] TO_LAST = {{(TO_BITS-1){1'b1}}, 1'b0};

  state_t             r_state, w_state_next;
  logic               r_cmd_wr, w_cmd_wr_next;
  logic [7:0]         r_dbg_a, w_dbg_a_next;
  logic [15:0]        r_dbg_di, w_dbg_di_next;
  logic [15:0]        r_resp, w_resp_next;
  logic [7:0]         r_tx_data, w_tx_data_next;
  logic               r_rd_ok, w_rd_ok_next;
  logic [TO_BITS-1:0] r_to_cnt, w_to_cnt_next;
  logic               r_we, r_rd, r_tx_valid, r_busy, r_rx_drop;
  logic               w_we_next, w_rd_next, w_tx_valid_next, w_busy_next, w_rx_drop_next;
  logic               w_rx_cmd, w_tx_fire, w_to_hit;

  assign w_rx_cmd  = (bus.rx_data == 8'h57) || (bus.rx_data == 8'h52);
  assign w_tx_fire = r_tx_valid && bus.tx_ready;
  assign w_to_hit  = (r_to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (bus.rx_valid) w_state_next = w_rx_cmd ? S_GET_ADDR : S_RESP1;
      S_GET_ADDR: if (bus.rx_valid) w_state_next = r_cmd_wr ? S_GET_DHI : S_XFER;
      S_GET_DHI:  if (bus.rx_valid) w_state_next = S_GET_DLO;
      S_GET_DLO:  if (bus.rx_valid) w_state_next = S_XFER;
      S_XFER:     if (bus.dbg_ready || w_to_hit) w_state_next = S_RESP1;
      S_RESP1:    if (w_tx_fire) w_state_next = r_rd_ok ? S_RESP2 : S_IDLE;
      S_RESP2:    if (w_tx_fire) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_wr_next  = r_cmd_wr;
    w_dbg_a_next   = r_dbg_a;
    w_dbg_di_next  = r_dbg_di;
    w_resp_next    = r_resp;
    w_tx_data_next = r_tx_data;
    w_rd_ok_next   = r_rd_ok;
    w_to_cnt_next  = r_to_cnt;
    case (r_state)
      S_IDLE: if (bus.rx_valid) begin
        if (w_rx_cmd) begin
          w_cmd_wr_next = (bus.rx_data == 8'h57);
        end else begin
          w_tx_data_next = 8'h3F;
          w_rd_ok_next   = 1'b0;
        end
      end
      S_GET_ADDR: if (bus.rx_valid) w_dbg_a_next = bus.rx_data;
      S_GET_DHI:  if (bus.rx_valid) w_dbg_di_next[15:8] = bus.rx_data;
      S_GET_DLO:  if (bus.rx_valid) w_dbg_di_next[7:0] = bus.rx_data;
      S_XFER: begin
        // Ready wins over a simultaneous terminal count.
        if (bus.dbg_ready) begin
          w_rd_ok_next = !r_cmd_wr;
          if (r_cmd_wr) begin
            w_tx_data_next = 8'h4B;
          end else begin
            w_resp_next    = bus.dbg_do;
            w_tx_data_next = bus.dbg_do[15:8];
          end
        end else if (w_to_hit) begin
          w_tx_data_next = 8'h54;
          w_rd_ok_next   = 1'b0;
        end else begin
          w_to_cnt_next = r_to_cnt + 1'b1;
        end
      end
      S_RESP1: if (w_tx_fire && r_rd_ok) w_tx_data_next = r_resp[7:0];
      default: ;
    endcase
    if ((w_state_next == S_XFER) && (r_state != S_XFER)) w_to_cnt_next = '0;

    w_we_next       = (w_state_next == S_XFER) && r_cmd_wr;
    w_rd_next       = (w_state_next == S_XFER) && !r_cmd_wr;
    w_tx_valid_next = (w_state_next == S_RESP1) || (w_state_next == S_RESP2);
    w_busy_next     = (w_state_next != S_IDLE);
    w_rx_drop_next  = bus.rx_valid &&
                      ((r_state == S_XFER) || (r_state == S_RESP1) || (r_state == S_RESP2));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cmd_wr   <= 1'b0;
      r_dbg_a    <= '0;
      r_dbg_di   <= '0;
      r_resp     <= '0;
      r_tx_data  <= '0;
      r_rd_ok    <= 1'b0;
      r_to_cnt   <= '0;
      r_we       <= 1'b0;
      r_rd       <= 1'b0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_rx_drop  <= 1'b0;
    end else begin
      r_cmd_wr   <= w_cmd_wr_next;
      r_dbg_a    <= w_dbg_a_next;
      r_dbg_di   <= w_dbg_di_next;
      r_resp     <= w_resp_next;
      r_tx_data  <= w_tx_data_next;
      r_rd_ok    <= w_rd_ok_next;
      r_to_cnt   <= w_to_cnt_next;
      r_we       <= w_we_next;
      r_rd       <= w_rd_next;
      r_tx_valid <= w_tx_valid_next;
      r_busy     <= w_busy_next;
      r_rx_drop  <= w_rx_drop_next;
    end
  end

  assign bus.tx_data  = r_tx_data;
  assign bus.tx_valid = r_tx_valid;
  assign bus.dbg_a    = r_dbg_a;
  assign bus.dbg_di   = r_dbg_di;
  assign bus.dbg_we   = r_we;
  assign bus.dbg_rd   = r_rd;
  assign bus.busy     = r_busy;
  assign bus.rx_drop  = r_rx_drop;
endmodule

// File: tb/tb_debug_cmd_bridge.sv
// Directed bench for debug_cmd_bridge with a responder whose ready is
// combinational from the strobes after a programmable number of wait cycles.
module tb_debug_cmd_bridge;
  logic clk;
  logic rst_n;
  debug_cmd_bridge_if bus ();

  debug_cmd_bridge #(.TO_BITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  logic resp_en;
  int   resp_delay;
  int   strobe_cnt = 0;

  always @(posedge clk) strobe_cnt <= (bus.dbg_we || bus.dbg_rd) ? strobe_cnt + 1 : 0;
  assign bus.dbg_ready = (bus.dbg_we || bus.dbg_rd) && resp_en && (strobe_cnt == resp_delay);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  // Advances until tx_valid, counting strobe and read-completion cycles.
  task automatic run_xfer(input string tag, output int we_c, output int rd_c, output int ack_c);
    bit got;
    got = 0; we_c = 0; rd_c = 0; ack_c = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      if (bus.tx_valid) got = 1;
      else begin
        we_c  += int'(bus.dbg_we);
        rd_c  += int'(bus.dbg_rd);
        ack_c += int'(bus.dbg_rd && bus.dbg_ready);
        tick();
      end
    end
    chk({tag, "_txvalid"}, 64'(got), 64'd1);
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] exp);
    bus.tx_ready = 1'b1;
    chk(tag, {bus.tx_valid, bus.tx_data}, {1'b1, exp});
    tick();
  endtask

  int we_c, rd_c, ack_c, cnt;
  logic [7:0] held;

  initial begin
    rst_n = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    bus.dbg_do = 16'h0000;
    resp_en = 1'b1;
    resp_delay = 0;
    tick(); tick(); tick();
    chk("reset_outs", {bus.dbg_a, bus.dbg_di, bus.dbg_we, bus.dbg_rd, bus.tx_valid,
                       bus.tx_data, bus.busy, bus.rx_drop}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Write with combinational ready
    send_byte(8'h57);
    chk("wr_busy", 64'(bus.busy), 64'd1);
    send_byte(8'h14); send_byte(8'h12); send_byte(8'h34);
    chk("wr_strobe_rise", 64'(bus.dbg_we), 64'd1);
    chk("wr_addr_data", {bus.dbg_a, bus.dbg_di}, {8'h14, 16'h1234});
    run_xfer("wr", we_c, rd_c, ack_c);
    chk("wr_we_cycles", 64'(we_c), 64'd1);
    expect_tx("wr_tx_K", 8'h4B);
    chk("wr_idle", {bus.busy, bus.tx_valid}, 2'b00);

    // Read, ready after 5 wait cycles
    resp_delay = 5;
    bus.dbg_do = 16'hBEEF;
    send_byte(8'h52); send_byte(8'h20);
    run_xfer("rd", we_c, rd_c, ack_c);
    chk("rd_rd_cycles", 64'(rd_c), 64'd6);
    chk("rd_ack_cycles", 64'(ack_c), 64'd1);
    expect_tx("rd_tx_hi", 8'hBE);
    expect_tx("rd_tx_lo", 8'hEF);
    chk("rd_idle", {bus.busy, bus.tx_valid}, 2'b00);
    chk("rd_hold_a_di", {bus.dbg_a, bus.dbg_di}, {8'h20, 16'h1234});

    // Timeout: 2^4-1 strobe cycles
    resp_en = 1'b0;
    send_byte(8'h52); send_byte(8'h20);
    run_xfer("to", we_c, rd_c, ack_c);
    chk("to_rd_cycles", 64'(rd_c), 64'd15);
    chk("to_strobe_low", 64'(bus.dbg_rd), 64'd0);
    expect_tx("to_tx_T", 8'h54);
    chk("to_idle", 64'(bus.busy), 64'd0);

    // Unknown command byte, then a normal read
    resp_en = 1'b1;
    resp_delay = 0;
    send_byte(8'h41);
    run_xfer("unk", we_c, rd_c, ack_c);
    chk("unk_no_strobe", 64'(we_c + rd_c), 64'd0);
    expect_tx("unk_tx_q", 8'h3F);
    chk("unk_idle", {bus.busy, bus.tx_valid}, 2'b00);
    bus.dbg_do = 16'hA55A;
    send_byte(8'h52); send_byte(8'h10);
    run_xfer("rd2", we_c, rd_c, ack_c);
    chk("rd2_rd_cycles", 64'(rd_c), 64'd1);
    expect_tx("rd2_tx_hi", 8'hA5);
    expect_tx("rd2_tx_lo", 8'h5A);

    // Backpressure with a dropped byte in RESP1
    resp_delay = 2;
    bus.dbg_do = 16'hC3D2;
    bus.tx_ready = 1'b0;
    send_byte(8'h52); send_byte(8'h33);
    run_xfer("bp", we_c, rd_c, ack_c);
    send_byte(8'h57);
    chk("bp_drop_pulse", 64'(bus.rx_drop), 64'd1);
    held = bus.tx_data;
    chk("bp_hold_hi", 64'(held), 64'hC3);
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.rx_drop || bus.tx_data != held || !bus.tx_valid) cnt++;
    end
    chk("bp_stable_no_drop", 64'(cnt), 64'd0);
    expect_tx("bp_tx_hi", 8'hC3);
    expect_tx("bp_tx_lo", 8'hD2);
    chk("bp_idle", {bus.busy, bus.tx_valid}, 2'b00);

    // Reset in the middle of a stalled write
    resp_en = 1'b0;
    send_byte(8'h57); send_byte(8'h40); send_byte(8'hAB); send_byte(8'hCD);
    tick(); tick();
    chk("rst_mid_we_high", 64'(bus.dbg_we), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_outs", {bus.dbg_a, bus.dbg_di, bus.dbg_we, bus.dbg_rd, bus.tx_valid,
                         bus.tx_data, bus.busy, bus.rx_drop}, 64'd0);
    rst_n = 1'b1;
    resp_en = 1'b1;
    resp_delay = 0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.tx_valid || bus.busy) cnt++;
    end
    chk("rst_no_tx", 64'(cnt), 64'd0);
    send_byte(8'h57); send_byte(8'h41); send_byte(8'h00); send_byte(8'h07);
    run_xfer("post", we_c, rd_c, ack_c);
    chk("post_we_cycles", 64'(we_c), 64'd1);
    chk("post_addr_data", {bus.dbg_a, bus.dbg_di}, {8'h41, 16'h0007});
    expect_tx("post_tx_K", 8'h4B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
